// File: rtl/forward_pkg.sv
// Shared definitions for the operand-A forwarding detector: the opcodes
// that matter for destination decode and the register-address type.
package forward_pkg;

    typedef logic [4:0] regaddr_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

endpackage

// File: rtl/fwd_dest_decode.sv
// Works out whether the instruction held in one pipeline stage writes a
// register, and which one. Loads are only treated as writers when the
// stage actually has the load data in hand (allow_lw_i high).
module fwd_dest_decode
    import forward_pkg::*;
(
    input  logic [5:0] op_i,
    input  regaddr_t   rd_i,
    input  regaddr_t   rt_i,
    input  logic       allow_lw_i,
    output logic       writes_o,
    output regaddr_t   dest_o
);

    // Decode the opcode into a write-enable and destination; anything not
    // recognised as a writer reports no write and a zero destination.
    always_comb begin
        writes_o = 1'b0;
        dest_o   = '0;
        case (op_i)
            OP_RTYPE: begin
                writes_o = 1'b1;
                dest_o   = rd_i;
            end
            OP_ADDI: begin
                writes_o = 1'b1;
                dest_o   = rt_i;
            end
            OP_LW: begin
                if (allow_lw_i) begin
                    writes_o = 1'b1;
                    dest_o   = rt_i;
                end
            end
            default: begin
                writes_o = 1'b0;
                dest_o   = '0;
            end
        endcase
    end

endmodule

// File: rtl/forward_a_detect.sv
// Operand-A (rs) forwarding detector. Compares the EX and ID rs fields
// against the MEM and WB destinations, raises combinational forward flags,
// and counts how often each forwarding path is used.
module forward_a_detect
    import forward_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  regaddr_t         ex_rd,
    input  regaddr_t         ex_rs,
    input  regaddr_t         ex_rt,
    input  regaddr_t         id_rs,
    input  regaddr_t         id_rt,
    input  logic [5:0]       mem_op,
    input  regaddr_t         mem_rd,
    input  regaddr_t         mem_rs,
    input  regaddr_t         mem_rt,
    input  logic [5:0]       wb_op,
    input  regaddr_t         wb_rd,
    input  regaddr_t         wb_rs,
    input  regaddr_t         wb_rt,
    output logic             fwd_a_mem_to_ex,
    output logic             fwd_a_mem_to_id,
    output logic             fwd_a_wb_to_ex,
    output logic [CNT_W-1:0] cnt_mem_ex,
    output logic [CNT_W-1:0] cnt_mem_id,
    output logic [CNT_W-1:0] cnt_wb_ex
);

    logic     memWrites;
    regaddr_t memDest;
    logic     wbWrites;
    regaddr_t wbDest;
    logic     memValid;
    logic     wbValid;
    logic     memHitEx;
    logic     memHitId;
    logic     wbHitEx;
    logic [2:0] fwdFlags;

    // These fields exist only to keep the stage interfaces uniform.
    logic unusedInputs;
    assign unusedInputs = ^{ex_rd, ex_rt, id_rt, mem_rs, wb_rs};

    // A load's data is not ready in MEM (the hazard unit stalls instead),
    // so MEM decodes with loads excluded while WB includes them.
    fwd_dest_decode uMemDecode (
        .op_i       (mem_op),
        .rd_i       (mem_rd),
        .rt_i       (mem_rt),
        .allow_lw_i (1'b0),
        .writes_o   (memWrites),
        .dest_o     (memDest)
    );

    fwd_dest_decode uWbDecode (
        .op_i       (wb_op),
        .rd_i       (wb_rd),
        .rt_i       (wb_rt),
        .allow_lw_i (1'b1),
        .writes_o   (wbWrites),
        .dest_o     (wbDest)
    );

    // Register 0 is hard-wired, so a write to it never produces a value.
    assign memValid = memWrites && (memDest != '0);
    assign wbValid  = wbWrites && (wbDest != '0);

    // MEM holds the younger producer, so it shadows WB on the EX path.
    assign memHitEx = memValid && (memDest == ex_rs);
    assign memHitId = memValid && (memDest == id_rs);
    assign wbHitEx  = wbValid && (wbDest == ex_rs) && !memHitEx;

    assign fwd_a_mem_to_ex = memHitEx;
    assign fwd_a_mem_to_id = memHitId;
    assign fwd_a_wb_to_ex  = wbHitEx;

    assign fwdFlags = {wbHitEx, memHitId, memHitEx};

    // One saturating event counter per forwarding path.
    for (genvar g = 0; g < 3; g++) begin : gCounter
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;

        // Next count: hold at all-ones rather than wrapping to zero.
        always_comb begin
            count_d = count_q;
            if (fwdFlags[g] && (count_q != '1)) begin
                count_d = count_q + 1'b1;
            end
        end

        // Count register; reset wins over any pending increment.
        always_ff @(posedge clk) begin
            if (reset) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end
    end

    assign cnt_mem_ex = gCounter[0].count_q;
    assign cnt_mem_id = gCounter[1].count_q;
    assign cnt_wb_ex  = gCounter[2].count_q;

endmodule

// File: tb/tb_forward_a_detect.sv
// Self-checking bench for forward_a_detect: directed cases followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_forward_a_detect;

    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] ADDI  = 6'b001000;

    logic             clk;
    logic             reset;
    logic [4:0]       ex_rd, ex_rs, ex_rt, id_rs, id_rt;
    logic [5:0]       mem_op, wb_op;
    logic [4:0]       mem_rd, mem_rs, mem_rt, wb_rd, wb_rs, wb_rt;
    logic             fwd_a_mem_to_ex, fwd_a_mem_to_id, fwd_a_wb_to_ex;
    logic [CNT_W-1:0] cnt_mem_ex, cnt_mem_id, cnt_wb_ex;

    int checkCount = 0;
    int errorCount = 0;
    int modelCount[3];

    forward_a_detect #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_rd           (ex_rd),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .mem_op          (mem_op),
        .mem_rd          (mem_rd),
        .mem_rs          (mem_rs),
        .mem_rt          (mem_rt),
        .wb_op           (wb_op),
        .wb_rd           (wb_rd),
        .wb_rs           (wb_rs),
        .wb_rt           (wb_rt),
        .fwd_a_mem_to_ex (fwd_a_mem_to_ex),
        .fwd_a_mem_to_id (fwd_a_mem_to_id),
        .fwd_a_wb_to_ex  (fwd_a_wb_to_ex),
        .cnt_mem_ex      (cnt_mem_ex),
        .cnt_mem_id      (cnt_mem_id),
        .cnt_wb_ex       (cnt_wb_ex)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register an instruction writes, or -1 if it writes nothing usable.
    function automatic int destOf(input logic [5:0] op, input logic [4:0] rd,
                                  input logic [4:0] rt, input bit loadReady);
        int d;
        case (op)
            RTYPE:   d = int'(rd);
            ADDI:    d = int'(rt);
            LW:      d = loadReady ? int'(rt) : -1;
            default: d = -1;
        endcase
        if (d == 0) d = -1;
        return d;
    endfunction

    // Expected flags for the inputs currently driven.
    function automatic void modelFlags(output bit memEx, output bit memId, output bit wbEx);
        int md;
        int wd;
        md    = destOf(mem_op, mem_rd, mem_rt, 1'b0);
        wd    = destOf(wb_op, wb_rd, wb_rt, 1'b1);
        memEx = (md >= 0) && (md == int'(ex_rs));
        memId = (md >= 0) && (md == int'(id_rs));
        wbEx  = (wd >= 0) && (wd == int'(ex_rs)) && !memEx;
    endfunction

    // Advance the counter model across one clock edge.
    function automatic void updateModel();
        bit f[3];
        modelFlags(f[0], f[1], f[2]);
        for (int i = 0; i < 3; i++) begin
            if (reset) modelCount[i] = 0;
            else if (f[i] && modelCount[i] < CNT_MAX) modelCount[i] = modelCount[i] + 1;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check flags and counters, then clock it.
    task automatic applyStimulus(input logic rst, input logic [4:0] exRs, input logic [4:0] idRs,
                                 input logic [5:0] memOp, input logic [4:0] memRd,
                                 input logic [4:0] memRt, input logic [5:0] wbOp,
                                 input logic [4:0] wbRd, input logic [4:0] wbRt);
        bit eMemEx, eMemId, eWbEx;
        @(negedge clk);
        reset  = rst;
        ex_rs  = exRs;
        id_rs  = idRs;
        mem_op = memOp;
        mem_rd = memRd;
        mem_rt = memRt;
        wb_op  = wbOp;
        wb_rd  = wbRd;
        wb_rt  = wbRt;
        ex_rd  = 5'($urandom);
        ex_rt  = 5'($urandom);
        id_rt  = 5'($urandom);
        mem_rs = 5'($urandom);
        wb_rs  = 5'($urandom);
        #1;
        modelFlags(eMemEx, eMemId, eWbEx);
        checkOutput("memToEx", 32'(fwd_a_mem_to_ex), 32'(eMemEx));
        checkOutput("memToId", 32'(fwd_a_mem_to_id), 32'(eMemId));
        checkOutput("wbToEx", 32'(fwd_a_wb_to_ex), 32'(eWbEx));
        checkOutput("cntMemEx", 32'(cnt_mem_ex), 32'(modelCount[0]));
        checkOutput("cntMemId", 32'(cnt_mem_id), 32'(modelCount[1]));
        checkOutput("cntWbEx", 32'(cnt_wb_ex), 32'(modelCount[2]));
        @(posedge clk);
        updateModel();
    endtask

    // Keep the current inputs for n more edges without checking each one.
    task automatic holdCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            updateModel();
        end
    endtask

    function automatic logic [5:0] pickOp();
        logic [5:0] ops[7];
        ops = '{RTYPE, LW, SW, BEQ, BNE, JMP, ADDI};
        if ($urandom_range(0, 7) == 0) return 6'($urandom);
        return ops[$urandom_range(0, 6)];
    endfunction

    // Directed cases, counter scenarios, then randomized traffic.
    initial begin
        for (int i = 0; i < 3; i++) modelCount[i] = 0;
        reset = 1'b1;
        {ex_rd, ex_rs, ex_rt, id_rs, id_rt} = '0;
        {mem_op, mem_rd, mem_rs, mem_rt, wb_op, wb_rd, wb_rs, wb_rt} = '0;
        repeat (2) @(posedge clk);

        // Flag behaviour
        applyStimulus(1'b0, 5'd2, 5'd4, RTYPE, 5'd7, 5'd6, RTYPE, 5'd9, 5'd8);
        applyStimulus(1'b0, 5'd21, 5'd4, RTYPE, 5'd21, 5'd6, RTYPE, 5'd9, 5'd8);
        applyStimulus(1'b0, 5'd2, 5'd21, ADDI, 5'd7, 5'd21, RTYPE, 5'd9, 5'd8);
        applyStimulus(1'b0, 5'd21, 5'd21, LW, 5'd7, 5'd21, RTYPE, 5'd9, 5'd8);
        applyStimulus(1'b0, 5'd21, 5'd4, RTYPE, 5'd7, 5'd6, RTYPE, 5'd21, 5'd8);
        applyStimulus(1'b0, 5'd21, 5'd4, RTYPE, 5'd7, 5'd6, ADDI, 5'd9, 5'd21);
        applyStimulus(1'b0, 5'd21, 5'd4, RTYPE, 5'd7, 5'd6, LW, 5'd9, 5'd21);
        applyStimulus(1'b0, 5'd21, 5'd4, RTYPE, 5'd7, 5'd6, SW, 5'd9, 5'd21);
        applyStimulus(1'b0, 5'd21, 5'd4, RTYPE, 5'd7, 5'd6, BEQ, 5'd9, 5'd21);
        applyStimulus(1'b0, 5'd21, 5'd4, RTYPE, 5'd21, 5'd6, RTYPE, 5'd21, 5'd8);
        applyStimulus(1'b0, 5'd0, 5'd0, RTYPE, 5'd0, 5'd0, RTYPE, 5'd0, 5'd0);

        // Counters: clear, then five cycles on the MEM-to-EX path
        applyStimulus(1'b1, 5'd2, 5'd4, RTYPE, 5'd7, 5'd6, RTYPE, 5'd9, 5'd8);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 5'd21, 5'd4, RTYPE, 5'd21, 5'd6, RTYPE, 5'd9, 5'd8);
        applyStimulus(1'b0, 5'd2, 5'd4, RTYPE, 5'd7, 5'd6, RTYPE, 5'd9, 5'd8);
        #1;
        checkOutput("cntMemExFive", 32'(cnt_mem_ex), 32'd5);
        checkOutput("cntMemIdZero", 32'(cnt_mem_id), 32'd0);
        checkOutput("cntWbExZero", 32'(cnt_wb_ex), 32'd0);

        // Saturation on both MEM paths
        applyStimulus(1'b0, 5'd21, 5'd21, RTYPE, 5'd21, 5'd6, RTYPE, 5'd9, 5'd8);
        holdCycles(65540);
        applyStimulus(1'b0, 5'd21, 5'd21, RTYPE, 5'd21, 5'd6, RTYPE, 5'd9, 5'd8);
        #1;
        checkOutput("cntMemExSat", 32'(cnt_mem_ex), 32'(CNT_MAX));
        checkOutput("cntMemIdSat", 32'(cnt_mem_id), 32'(CNT_MAX));

        // Reset while the flag is still high
        applyStimulus(1'b1, 5'd21, 5'd21, RTYPE, 5'd21, 5'd6, RTYPE, 5'd9, 5'd8);
        #1;
        checkOutput("cntResetWins", 32'(cnt_mem_ex), 32'd0);

        // Randomized traffic with small register values to provoke matches
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 24) == 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          pickOp(), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          pickOp(), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        applyStimulus(1'b0, 5'd2, 5'd4, RTYPE, 5'd7, 5'd6, RTYPE, 5'd9, 5'd8);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/forward_a_detect.md
Name: forward_a_detect

Overview:
- Operand-A (rs) forwarding detector for the 5-stage pipelined MIPS-subset CPU.
- Compares the rs source of the instruction in EX, and of the instruction in ID, against the destination register of the instructions in MEM and WB.
- Raises one-hot-per-path forward flags that steer the A-operand muxes in EX and the ID-stage branch comparator.
- Also keeps per-path saturating forward-event counters for performance and debug observation.

Parameters:
- CNT_W, 16, width of each forward-event counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset; affects counters only.
- ex_rd  in  5  EX-stage rd; unused, kept for interface symmetry.
- ex_rs  in  5  EX-stage rs (operand A).
- ex_rt  in  5  EX-stage rt; unused.
- id_rs  in  5  ID-stage rs.
- id_rt  in  5  ID-stage rt; unused.
- mem_op  in  6  MEM-stage opcode.
- mem_rd  in  5  MEM-stage rd.
- mem_rs  in  5  MEM-stage rs; unused.
- mem_rt  in  5  MEM-stage rt.
- wb_op  in  6  WB-stage opcode.
- wb_rd  in  5  WB-stage rd.
- wb_rs  in  5  WB-stage rs; unused.
- wb_rt  in  5  WB-stage rt.
- fwd_a_mem_to_ex  out  1  forward MEM ALU result to the EX A-operand.
- fwd_a_mem_to_id  out  1  forward MEM ALU result to ID rs.
- fwd_a_wb_to_ex  out  1  forward WB write-back value to the EX A-operand.
- cnt_mem_ex  out  CNT_W  count of cycles with fwd_a_mem_to_ex=1.
- cnt_mem_id  out  CNT_W  count of cycles with fwd_a_mem_to_id=1.
- cnt_wb_ex  out  CNT_W  count of cycles with fwd_a_wb_to_ex=1.

Behaviour:
- Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, ADDI=001000.

Destination decode per stage:
- RTYPE writes rd.
- ADDI writes rt.
- LW writes rt.
- SW, BEQ, BNE, J and any unlisted opcode write nothing.
- A destination of register 0 never forwards.

MEM-stage writer:
- Only RTYPE and ADDI count as MEM-stage writers for forwarding.
- LW data is not available in MEM; that case is a load-use stall handled by the hazard unit, so no MEM forward is raised for LW.

WB-stage writer:
- RTYPE, ADDI and LW all count as WB-stage writers.

Flag equations:
- fwd_a_mem_to_ex = MEM writer && mem_dest!=0 && mem_dest==ex_rs.
- fwd_a_mem_to_id = MEM writer && mem_dest!=0 && mem_dest==id_rs.
- fwd_a_wb_to_ex = WB writer && wb_dest!=0 && wb_dest==ex_rs && !fwd_a_mem_to_ex. The most recent producer wins.

Flag timing:
- Flags are purely combinational, zero latency, and settle within the same cycle the inputs change.
- Flags are not registered and are unaffected by reset.

Counters:
- On each rising clk, when reset=0, each counter increments by 1 if its flag is 1.
- Counters saturate at all-ones and never wrap.
- reset=1 at a clock edge clears all counters to 0 and takes priority over increment.
- Reset value of all counters is 0.

Decomposition:
- Package forward_pkg holds the opcode localparams and a 5-bit regaddr_t typedef.
- One natural sub-module, fwd_dest_decode, takes (op, rd, rt, allow_lw) and returns (writes, dest).
  - Instantiate it twice: MEM with allow_lw=0, WB with allow_lw=1.
- Counters are one generate loop of three instances of the same saturating-counter logic.

Test Plan:
- Baseline: all opcodes RTYPE; ex_rs=2, id_rs=4, mem_rd=7, mem_rt=6, wb_rd=9, wb_rt=8 -> all three flags 0.
- MEM RTYPE mem_rd=21, ex_rs=21 -> fwd_a_mem_to_ex=1. ADDI mem_rt=21, id_rs=21 -> fwd_a_mem_to_id=1. LW mem_rt=21, ex_rs=21 -> both MEM flags 0.
- WB RTYPE wb_rd=21 / ADDI wb_rt=21 / LW wb_rt=21, each with ex_rs=21 -> fwd_a_wb_to_ex=1 in all three cases. SW or BEQ with wb_rt=21 -> 0.
- Priority: mem RTYPE mem_rd=21, wb RTYPE wb_rd=21, ex_rs=21 -> fwd_a_mem_to_ex=1, fwd_a_wb_to_ex=0.
- Zero register: RTYPE with mem_rd=0, ex_rs=0, id_rs=0 -> all flags 0.
- Counters:
  - reset high 1 cycle -> all counters 0.
  - Hold fwd_a_mem_to_ex=1 for 5 cycles -> cnt_mem_ex=5, others 0.
  - Preload via 65540 cycles -> saturates at 65535.
  - Assert reset while the flag is high -> counter 0 at the next edge.
